// File: rtl/zx_tape_dma.sv
// Tape-image loader: buffers a downloaded .o/.p image and copies it into main RAM
// when the CPU traps on the ROM LOAD entry, driving the loader-ROM patch signals.
module zx_tape_dma #(
    parameter int                ADDR_W = 14,
    parameter int                RAM_AW = 16,
    parameter logic [RAM_AW-1:0] BASE_O = 16'h4000,
    parameter logic [RAM_AW-1:0] BASE_P = 16'h4009
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    input  logic              dl_fmt,
    input  logic              trap_hit,
    input  logic              trap_exit,
    input  logic              cpu_ce,
    input  logic              burst,
    output logic              ram_req,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_data,
    input  logic              ram_ack,
    output logic              loading,
    output logic              patch_carry,
    output logic              tape_ready,
    output logic [ADDR_W:0]   tape_size,
    output logic [7:0]        checksum,
    output logic              overflow
);

    typedef enum logic [2:0] {IDLE, FETCH, RDWAIT, WRITE, DONE} state_t;

    state_t          state;
    logic [7:0]      mem [2**ADDR_W];
    logic [7:0]      rd_byte;
    logic [ADDR_W:0] idx;
    logic [ADDR_W:0] max_idx;
    logic [RAM_AW:0] dest;
    logic [RAM_AW:0] next_dest;
    logic            fmt;
    logic            dl_active_q;
    logic            dl_rise;
    logic            dl_fall;
    logic            step;

    assign dl_rise    = dl_active & ~dl_active_q;
    assign dl_fall    = ~dl_active & dl_active_q;
    assign tape_ready = (tape_size != '0);
    assign ram_addr   = dest[RAM_AW-1:0];
    assign step       = (state == FETCH) && (idx != tape_size) && (cpu_ce || burst);
    // One bit wider than RAM so a carry out of the top marks the overflow.
    assign next_dest  = (fmt ? {1'b0, BASE_P} : {1'b0, BASE_O}) + (RAM_AW+1)'(idx);

    // Image store: download write port and loader read port never contend.
    always_ff @(posedge clk_sys) begin
        if (dl_wr)
            mem[dl_addr] <= dl_data;
        if (step)
            rd_byte <= mem[idx[ADDR_W-1:0]];
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_active_q <= 1'b0;
            max_idx     <= '0;
            tape_size   <= '0;
            fmt         <= 1'b0;
        end else begin
            dl_active_q <= dl_active;
            if (dl_rise)
                max_idx <= '0;
            else if (dl_wr && ({1'b0, dl_addr} >= max_idx))
                max_idx <= {1'b0, dl_addr} + (ADDR_W+1)'(1);
            if (dl_rise) begin
                tape_size <= '0;
            end else if (dl_fall) begin
                tape_size <= max_idx;
                fmt       <= dl_fmt;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            dest        <= '0;
            ram_req     <= 1'b0;
            ram_data    <= '0;
            loading     <= 1'b0;
            patch_carry <= 1'b0;
            checksum    <= '0;
            overflow    <= 1'b0;
        end else if (dl_rise || trap_exit) begin
            // Abort; checksum and overflow keep the result of the last load.
            state       <= IDLE;
            loading     <= 1'b0;
            patch_carry <= 1'b0;
            ram_req     <= 1'b0;
        end else if (trap_hit) begin
            idx      <= '0;
            checksum <= '0;
            overflow <= 1'b0;
            loading  <= 1'b1;
            ram_req  <= 1'b0;
            if (tape_ready) begin
                state       <= FETCH;
                patch_carry <= 1'b0;
            end else begin
                state       <= DONE;
                patch_carry <= 1'b1;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (idx == tape_size) begin
                        state       <= DONE;
                        patch_carry <= 1'b1;
                    end else if (cpu_ce || burst) begin
                        state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    dest     <= next_dest;
                    ram_data <= rd_byte;
                    ram_req  <= ~next_dest[RAM_AW];
                    state    <= WRITE;
                end
                WRITE: begin
                    if (dest[RAM_AW]) begin
                        overflow    <= 1'b1;
                        patch_carry <= 1'b1;
                        state       <= DONE;
                    end else if (ram_ack) begin
                        ram_req  <= 1'b0;
                        idx      <= idx + (ADDR_W+1)'(1);
                        checksum <= checksum + ram_data;
                        state    <= FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_zx_tape_dma.sv
// Bench for zx_tape_dma: directed scenarios plus randomized images checked
// against a list-of-writes model; a second instance sits near the top of RAM.
module tb_zx_tape_dma;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset_n, dl_active, dl_wr, dl_fmt, trap_hit, trap_exit;
    logic          cpu_ce, burst, ram_ack;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;

    logic          ram_req, loading, patch_carry, tape_ready, overflow;
    logic [15:0]   ram_addr;
    logic [7:0]    ram_data, checksum;
    logic [AW:0]   tape_size;
    logic          ram_req_b, loading_b, patch_carry_b, tape_ready_b, overflow_b;
    logic [15:0]   ram_addr_b;
    logic [7:0]    ram_data_b, checksum_b;
    logic [AW:0]   tape_size_b;

    int total = 0, bad = 0, cyc = 0;
    int ack_mode = 0, ce_per = 0;
    int last_ack, pc_cyc;
    logic [7:0]  img [$];
    logic [15:0] wa [$], wa_b [$];
    logic [7:0]  wd [$], wd_b [$];
    int          rise [$];
    logic        req_q = 1'b0, ack_q = 1'b0;
    logic [15:0] addr_q;
    logic [7:0]  data_q;

    zx_tape_dma #(.ADDR_W(AW)) u_dut (
        .clk_sys(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_fmt(dl_fmt), .trap_hit(trap_hit),
        .trap_exit(trap_exit), .cpu_ce(cpu_ce), .burst(burst), .ram_req(ram_req),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_ack(ram_ack), .loading(loading),
        .patch_carry(patch_carry), .tape_ready(tape_ready), .tape_size(tape_size),
        .checksum(checksum), .overflow(overflow));

    zx_tape_dma #(.ADDR_W(AW), .BASE_O(16'hFFFE)) u_top (
        .clk_sys(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_fmt(dl_fmt), .trap_hit(trap_hit),
        .trap_exit(trap_exit), .cpu_ce(cpu_ce), .burst(burst), .ram_req(ram_req_b),
        .ram_addr(ram_addr_b), .ram_data(ram_data_b), .ram_ack(1'b1), .loading(loading_b),
        .patch_carry(patch_carry_b), .tape_ready(tape_ready_b), .tape_size(tape_size_b),
        .checksum(checksum_b), .overflow(overflow_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Ack and CPU clock-enable generators
    always @(posedge clk) begin
        #1;
        case (ack_mode)
            0:       ram_ack = 1'b1;
            1:       ram_ack = (cyc % 4 == 0);
            2:       ram_ack = 1'b0;
            default: ram_ack = 1'($urandom_range(0, 1));
        endcase
        cpu_ce = (ce_per != 0) && (cyc % ce_per == 0);
    end

    // Write log plus request-stability check
    always @(negedge clk) begin
        if (ram_req && ram_ack) begin
            wa.push_back(ram_addr);
            wd.push_back(ram_data);
            last_ack = cyc;
        end
        if (ram_req && !req_q) rise.push_back(cyc);
        if (req_q && !ack_q && ram_req) begin
            chk("hold_addr", 32'(ram_addr), 32'(addr_q));
            chk("hold_data", 32'(ram_data), 32'(data_q));
        end
        req_q = ram_req; ack_q = ram_ack; addr_q = ram_addr; data_q = ram_data;
        if (ram_req_b) begin
            wa_b.push_back(ram_addr_b);
            wd_b.push_back(ram_data_b);
        end
    end

    // Reference: byte i lands at base+i until the address leaves the 64K space.
    task automatic model(input int base, output int n, output logic ov, output logic [7:0] ck);
        n = 0; ov = 1'b0; ck = 8'h00;
        foreach (img[i]) begin
            if (base + i > 'hFFFF) begin
                ov = 1'b1;
                break;
            end
            n++;
            ck = ck + img[i];
        end
    endtask

    task automatic download(input logic f);
        @(posedge clk); #1 dl_active = 1'b1; dl_fmt = f;
        foreach (img[i]) begin
            @(posedge clk); #1 dl_wr = 1'b1; dl_addr = AW'(i); dl_data = img[i];
        end
        @(posedge clk); #1 dl_wr = 1'b0;
        @(posedge clk); #1 dl_active = 1'b0;
        @(posedge clk); #1;
        chk("tape_size", 32'(tape_size), 32'(img.size()));
        chk("tape_ready", 32'(tape_ready), 32'(img.size() != 0));
    endtask

    task automatic pulse_trap();
        @(posedge clk); #1 trap_hit = 1'b1;
        @(posedge clk); #1 trap_hit = 1'b0;
        chk("loading_n1", 32'(loading), 1);
    endtask

    task automatic pulse_exit();
        @(posedge clk); #1 trap_exit = 1'b1;
        @(posedge clk); #1 trap_exit = 1'b0;
    endtask

    task automatic run_load(input logic f);
        int n, nb, t;
        logic ov, ovb;
        logic [7:0] ck, ckb;
        int base  = f ? 'h4009 : 'h4000;
        int baseb = f ? 'h4009 : 'hFFFE;
        wa.delete(); wd.delete(); wa_b.delete(); wd_b.delete(); rise.delete();
        pc_cyc = -1;
        pulse_trap();
        t = 0;
        while (!(patch_carry && patch_carry_b) && t < 3000) begin
            @(negedge clk);
            if (patch_carry && pc_cyc < 0) pc_cyc = cyc;
            t++;
        end
        chk("load_timeout", 32'(t < 3000), 1);
        model(base, n, ov, ck);
        model(baseb, nb, ovb, ckb);
        chk("n_writes", 32'(wa.size()), 32'(n));
        for (int i = 0; i < n && i < wa.size(); i++) begin
            chk("wr_addr", 32'(wa[i]), 32'(base + i));
            chk("wr_data", 32'(wd[i]), 32'(img[i]));
        end
        chk("checksum", 32'(checksum), 32'(ck));
        chk("overflow", 32'(overflow), 32'(ov));
        chk("loading_done", 32'(loading), 1);
        if (n > 0) chk("pc_latency", 32'(pc_cyc - last_ack), 2);
        chk("n_writes_top", 32'(wa_b.size()), 32'(nb));
        for (int i = 0; i < nb && i < wa_b.size(); i++) begin
            chk("wr_addr_top", 32'(wa_b[i]), 32'(baseb + i));
            chk("wr_data_top", 32'(wd_b[i]), 32'(img[i]));
        end
        chk("checksum_top", 32'(checksum_b), 32'(ckb));
        chk("overflow_top", 32'(overflow_b), 32'(ovb));
    endtask

    task automatic finish_load();
        logic [7:0] ck = checksum;
        logic ov = overflow;
        pulse_exit();
        chk("exit_loading", 32'(loading), 0);
        chk("exit_pc", 32'(patch_carry), 0);
        chk("exit_ck_hold", 32'(checksum), 32'(ck));
        chk("exit_ov_hold", 32'(overflow), 32'(ov));
    endtask

    initial begin
        int len, t;
        logic f;
        reset_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_fmt = 1'b0; dl_addr = '0;
        dl_data = '0; trap_hit = 1'b0; trap_exit = 1'b0; burst = 1'b1;
        cpu_ce = 1'b0; ram_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(ram_req), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_data", 32'(ram_data), 0);
        chk("rst_flags", 32'({loading, patch_carry, tape_ready, overflow}), 0);
        chk("rst_size", 32'(tape_size), 0);
        chk("rst_ck", 32'(checksum), 0);
        reset_n = 1'b1;

        // .o burst, ack high; top instance overflows after FFFE, FFFF
        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        download(1'b0);
        run_load(1'b0);
        chk("ck_AA", 32'(checksum), 'hAA);
        chk("top_ov", 32'(overflow_b), 1);
        chk("top_pc", 32'(patch_carry_b), 1);
        finish_load();

        // .p with slow ack
        img = '{8'hFF, 8'h01, 8'h02};
        ack_mode = 1;
        download(1'b1);
        run_load(1'b1);
        chk("ck_02", 32'(checksum), 'h02);
        finish_load();

        // Paced: one request per cpu_ce
        img = '{8'h5A, 8'hA5};
        ack_mode = 0; burst = 1'b0; ce_per = 8;
        download(1'b0);
        run_load(1'b0);
        chk("paced_reqs", 32'(rise.size()), 2);
        if (rise.size() == 2) chk("paced_gap", 32'(rise[1] - rise[0]), 8);
        finish_load();

        // trap_exit while a request is pending, then restart
        img = '{8'h01, 8'h02, 8'h03};
        burst = 1'b1; ce_per = 0; ack_mode = 2;
        download(1'b0);
        pulse_trap();
        t = 0;
        while (!ram_req && t < 20) begin @(negedge clk); t++; end
        chk("pend_req", 32'(ram_req), 1);
        pulse_exit();
        chk("abort_req", 32'(ram_req), 0);
        chk("abort_loading", 32'(loading), 0);
        ack_mode = 0;
        run_load(1'b0);
        finish_load();

        // New download mid-load, then empty-buffer trap
        img = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        ack_mode = 2;
        download(1'b0);
        pulse_trap();
        t = 0;
        while (!ram_req && t < 20) begin @(negedge clk); t++; end
        @(posedge clk); #1 dl_active = 1'b1;
        @(posedge clk); #1;
        chk("dl_abort_loading", 32'(loading), 0);
        chk("dl_abort_ready", 32'(tape_ready), 0);
        chk("dl_abort_req", 32'(ram_req), 0);
        dl_active = 1'b0;
        repeat (2) @(posedge clk);
        #1 ack_mode = 0;
        chk("empty_size", 32'(tape_size), 0);
        wa.delete();
        pulse_trap();
        chk("empty_pc", 32'(patch_carry), 1);
        repeat (6) @(posedge clk);
        #1 chk("empty_writes", 32'(wa.size()), 0);
        finish_load();

        // Randomized images
        for (int k = 0; k < 12; k++) begin
            len = $urandom_range(1, 40);
            img.delete();
            for (int i = 0; i < len; i++) img.push_back(8'($urandom));
            f = 1'($urandom_range(0, 1));
            burst = 1'($urandom_range(0, 1));
            ce_per = burst ? 0 : $urandom_range(3, 6);
            ack_mode = $urandom_range(0, 2);
            if (ack_mode == 2) ack_mode = 3;
            download(f);
            run_load(f);
            finish_load();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
